// File: rtl/gpio_output_driver_if.sv
// Command port and pin-state readback between the bus decoder and gpio_output_driver.
// Master is the bus decoder; slave is the output driver.
interface gpio_output_driver_if #(
    parameter int N       = 16,
    parameter int PULSE_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [N-1:0]       cmd_mask;
    logic [N-1:0]       cmd_data;
    logic [PULSE_W-1:0] cmd_len;
    logic [N-1:0]       gpio_out;
    logic [N-1:0]       level;
    logic [N-1:0]       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_len,
        input  cmd_ready, gpio_out, level, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_mask, cmd_data, cmd_len,
        output cmd_ready, gpio_out, level, busy
    );
endinterface

// File: rtl/gpio_output_driver.sv
// Bank of N registered GPIO outputs with masked write/set/clear/toggle and tick-timed one-shot pulses.
// One cycle level->pin latency; cmd_ready is always 1 after reset. Pulses need GPIO_OUTPUT_DRIVER_PULSE_EN.
module gpio_output_driver #(
    parameter int             N         = 16,
    parameter int             PRESCALE  = 16,
    parameter int             PULSE_W   = 8,
    parameter logic [N-1:0]   RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    gpio_output_driver_if.slave  bus
);
    localparam logic [2:0] OP_WRITE  = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;

    logic         ready_q;
    logic         accept;
    logic [N-1:0] level_q, level_d;
    logic [N-1:0] gpio_q, gpio_d;
    logic [N-1:0] busy;

    assign accept = bus.cmd_valid && ready_q;

    always_comb begin
        level_d = level_q;
        if (accept) begin
            case (bus.cmd_op)
                OP_WRITE:  level_d = (level_q & ~bus.cmd_mask) | (bus.cmd_data & bus.cmd_mask);
                OP_SET:    level_d = level_q | bus.cmd_mask;
                OP_CLEAR:  level_d = level_q & ~bus.cmd_mask;
                OP_TOGGLE: level_d = level_q ^ bus.cmd_mask;
                default:   level_d = level_q;
            endcase
        end
    end

`ifdef GPIO_OUTPUT_DRIVER_PULSE_EN
    localparam logic [2:0] OP_PULSE = 3'b100;

    logic [PRESCALE-1:0] presc_q;
    logic                tick;
    logic                pulse_cmd;
    logic [PULSE_W-1:0]  cnt_q [N];
    logic [PULSE_W-1:0]  cnt_d [N];

    assign tick      = &presc_q;
    assign pulse_cmd = accept && (bus.cmd_op == OP_PULSE) && (bus.cmd_len != '0);

    // A load on the same edge as a tick wins, so the new length is never shortened.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            cnt_d[i] = cnt_q[i];
            busy[i]  = (cnt_q[i] != '0);
            if (pulse_cmd && bus.cmd_mask[i]) begin
                cnt_d[i] = bus.cmd_len;
            end else if (tick && busy[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q <= presc_q + 1'b1;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    logic unused_len;

    assign unused_len = ^bus.cmd_len;
    assign busy       = '0;
`endif

    // Pin is inverted relative to its level while a pulse is running.
    assign gpio_d = level_q ^ busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
            level_q <= RESET_VAL;
            gpio_q  <= RESET_VAL;
        end else begin
            ready_q <= 1'b1;
            level_q <= level_d;
            gpio_q  <= gpio_d;
        end
    end

    assign bus.cmd_ready = ready_q;
    assign bus.level     = level_q;
    assign bus.gpio_out  = gpio_q;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_gpio_output_driver.sv
// Directed bench for gpio_output_driver with N=4, PRESCALE=2, PULSE_W=4, RESET_VAL=0.
// Pulse scenarios run when GPIO_OUTPUT_DRIVER_PULSE_EN is defined, no-op scenarios otherwise.
module tb_gpio_output_driver;
    localparam int N        = 4;
    localparam int PRESCALE = 2;
    localparam int PULSE_W  = 4;

    localparam logic [2:0] OP_WRITE  = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_PULSE  = 3'b100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    gpio_output_driver_if #(.N(N), .PULSE_W(PULSE_W)) bus ();

    gpio_output_driver #(
        .N(N), .PRESCALE(PRESCALE), .PULSE_W(PULSE_W), .RESET_VAL(4'b0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Presents one command for one edge; returns #1 after the acceptance edge.
    task automatic issue(input logic [2:0] op, input logic [3:0] mask,
                         input logic [3:0] data, input logic [3:0] len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_mask  = mask;
        bus.cmd_data  = data;
        bus.cmd_len   = len;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Counts edges until the pin returns to lvl; width = inverted samples, gap = pin fall minus busy fall.
    task automatic measure(input int pin, input logic lvl, output int width, output int gap);
        int ib = -1;
        int ig = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (ib < 0 && !bus.busy[pin]) ib = i;
            if (bus.gpio_out[pin] == lvl) begin
                ig = i;
                break;
            end
        end
        if (ig < 0) begin
            width = -1;
            gap   = -1;
        end else begin
            width = ig - 1;
            gap   = ig - ib;
        end
    endtask

    task automatic reset_mid_op();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("rst_gpio",  32'(bus.gpio_out), 32'h0);
        check("rst_level", 32'(bus.level),    32'h0);
        check("rst_busy",  32'(bus.busy),     32'h0);
        check("rst_ready", 32'(bus.cmd_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_ready_pre", 32'(bus.cmd_ready), 32'h0);
        @(posedge clk);
        #1;
        check("rel_ready", 32'(bus.cmd_ready), 32'h1);
        check("rel_gpio",  32'(bus.gpio_out),  32'h0);
    endtask

    logic [2:0] v_op   [4] = '{OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE};
    logic [3:0] v_mask [4] = '{4'b1111, 4'b0001, 4'b1000, 4'b0110};
    logic [3:0] v_data [4] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000};
    logic [3:0] v_exp  [4] = '{4'b1010, 4'b1011, 4'b0011, 4'b0101};

    initial begin
        int         w;
        int         g;
        logic [3:0] prev;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_mask  = '0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;

        #1;
        check("init_gpio",  32'(bus.gpio_out),  32'h0);
        check("init_busy",  32'(bus.busy),      32'h0);
        check("init_ready", 32'(bus.cmd_ready), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("ready_before_edge", 32'(bus.cmd_ready), 32'h0);
        @(posedge clk);
        #1;
        check("ready_after_edge", 32'(bus.cmd_ready), 32'h1);

        // Back-to-back masked ops, pin follows level one edge later.
        prev = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = v_op[k];
            bus.cmd_mask  = v_mask[k];
            bus.cmd_data  = v_data[k];
            @(posedge clk);
            #1;
            check($sformatf("op%0d_level", k), 32'(bus.level),    32'(v_exp[k]));
            check($sformatf("op%0d_gpio", k),  32'(bus.gpio_out), 32'(prev));
            prev = v_exp[k];
        end
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check("op3_gpio_final", 32'(bus.gpio_out), 32'h5);

`ifdef GPIO_OUTPUT_DRIVER_PULSE_EN
        issue(OP_WRITE, 4'b1111, 4'b0000, 4'd0);
        @(posedge clk);
        #1;
        check("clr_gpio", 32'(bus.gpio_out), 32'h0);

        issue(OP_PULSE, 4'b0100, 4'b0000, 4'd3);
        check("p3_busy_at_A", 32'(bus.busy),     32'h4);
        check("p3_gpio_at_A", 32'(bus.gpio_out), 32'h0);
        check("p3_level",     32'(bus.level),    32'h0);
        measure(2, 1'b0, w, g);
        check("p3_width_9_12", 32'(w >= 9 && w <= 12), 32'h1);
        check("p3_busy_lead",  32'(g), 32'h1);
        check("p3_end_busy",   32'(bus.busy), 32'h0);

        issue(OP_PULSE, 4'b1111, 4'b0000, 4'd0);
        check("p0_busy", 32'(bus.busy), 32'h0);
        @(posedge clk);
        #1;
        check("p0_gpio", 32'(bus.gpio_out), 32'h0);

        issue(OP_PULSE, 4'b0010, 4'b0000, 4'd2);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rt_busy_mid", 32'(bus.busy), 32'h2);
        issue(OP_PULSE, 4'b0010, 4'b0000, 4'd4);
        measure(1, 1'b0, w, g);
        check("rt_width_13_16", 32'(w >= 13 && w <= 16), 32'h1);

        issue(OP_PULSE, 4'b0001, 4'b0000, 4'd3);
        @(posedge clk);
        #1;
        check("lc_gpio_pulsing", 32'(bus.gpio_out), 32'h1);
        issue(OP_SET, 4'b0001, 4'b0000, 4'd0);
        check("lc_level", 32'(bus.level),    32'h1);
        check("lc_gpio_a", 32'(bus.gpio_out), 32'h1);
        @(posedge clk);
        #1;
        check("lc_gpio_inv", 32'(bus.gpio_out), 32'h0);
        check("lc_busy",     32'(bus.busy),     32'h1);
        measure(0, 1'b1, w, g);
        check("lc_returns", 32'(w > 0), 32'h1);
        check("lc_gap",     32'(g),     32'h1);
        check("lc_level_end", 32'(bus.level), 32'h1);

        issue(OP_PULSE, 4'b1000, 4'b0000, 4'd5);
        check("abort_busy_pre", 32'(bus.busy), 32'h8);
        reset_mid_op();
        check("abort_busy_post", 32'(bus.busy), 32'h0);
`else
        issue(OP_WRITE, 4'b1111, 4'b0101, 4'd0);
        @(posedge clk);
        #1;
        check("np_gpio_base", 32'(bus.gpio_out), 32'h5);
        issue(OP_PULSE, 4'b1111, 4'b0000, 4'd5);
        check("np_level", 32'(bus.level), 32'h5);
        check("np_busy",  32'(bus.busy),  32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("np_gpio_%0d", i), 32'(bus.gpio_out), 32'h5);
            check($sformatf("np_busy_%0d", i), 32'(bus.busy),     32'h0);
        end
        issue(OP_WRITE, 4'b1111, 4'b1010, 4'd0);
        check("np_wr_gpio_A", 32'(bus.gpio_out), 32'h5);
        @(posedge clk);
        #1;
        check("np_wr_gpio_A1", 32'(bus.gpio_out), 32'hA);
        reset_mid_op();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
